// File: rtl/rsa_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_arb_pkg
// Description : Shared types, defaults and width helpers for the RSA engine
//               arbiter and its round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_LOAD  = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_t;

   localparam int K_DEF   = 2048;
   localparam int FDW_DEF = 32;
   localparam int WPO     = K_DEF / FDW_DEF;

   // Word counter spans both operands (2*WPO transfers) in LOAD.
   function automatic int cnt_width(input int wpo);
      return $clog2(2 * wpo + 1);
   endfunction

   function automatic int tmo_width(input int tmo);
      return $clog2(tmo + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rsa_rr_pick
// Description : Combinational round-robin picker: first set request bit
//               scanning cyclically upward from rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_rr_pick #(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]         req,
   input  logic [$clog2(NCH)-1:0] rr_ptr,
   output logic [$clog2(NCH)-1:0] pick,
   output logic                   any
);

   localparam int C_PW = $clog2(NCH);

   always_comb begin
      pick = '0;
      any  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!any && req[C_PW'((int'(rr_ptr) + i) % NCH)]) begin
            any  = 1'b1;
            pick = C_PW'((int'(rr_ptr) + i) % NCH);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rsa_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rsa_engine_arbiter
// Description : Round-robin sharing of one modexp stream engine between NCH
//               channels, with a DRAIN no-progress timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_engine_arbiter
   import rsa_arb_pkg::*;
#(
   parameter int NCH = 4,
   parameter int FDW = FDW_DEF,
   parameter int K   = WPO * FDW_DEF,
   parameter int TMO = 2**20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic [NCH-1:0]         req,
   output logic [NCH-1:0]         gnt,
   output logic                   busy,
   output logic                   err,
   output logic [$clog2(NCH)-1:0] err_ch,
   input  logic [NCH-1:0]         in_vld,
   input  logic [NCH*FDW-1:0]     in_data,
   output logic [NCH-1:0]         in_rdy,
   output logic [NCH-1:0]         out_vld,
   output logic [FDW-1:0]         out_data,
   input  logic [NCH-1:0]         out_rdy,
   output logic                   eng_start,
   output logic                   eng_vld,
   output logic [FDW-1:0]         eng_din,
   input  logic                   eng_rdy,
   input  logic                   eng_res_vld,
   input  logic [FDW-1:0]         eng_res_data,
   output logic                   eng_res_rdy
);

   localparam int C_WPO = K / FDW;
   localparam int C_PW  = $clog2(NCH);
   localparam int C_CW  = cnt_width(C_WPO);
   localparam int C_TW  = tmo_width(TMO);

   arb_state_t      r_state, w_state_nxt;
   logic [NCH-1:0]  r_gnt, w_gnt_nxt;
   logic [C_PW-1:0] r_gnt_idx, w_gnt_idx_nxt;
   logic [C_PW-1:0] r_rr_ptr, w_rr_ptr_nxt;
   logic [C_PW-1:0] r_err_ch, w_err_ch_nxt;
   logic [C_PW-1:0] w_pick, w_g_next;
   logic [C_CW-1:0] r_cnt, w_cnt_nxt;
   logic [C_TW-1:0] r_tmo, w_tmo_nxt;
   logic            r_err, w_err_nxt;
   logic            w_any, w_in_xfer, w_res_xfer;

   rsa_rr_pick #(.NCH(NCH)) u_pick (
      .req    (req),
      .rr_ptr (r_rr_ptr),
      .pick   (w_pick),
      .any    (w_any)
   );

   // Datapath steering: the one-hot grant selects the channel, state gates it.
   always_comb begin
      eng_din = '0;
      for (int i = 0; i < NCH; i++) begin
         if (r_gnt[i]) eng_din = in_data[i*FDW +: FDW];
      end
   end

   assign eng_vld     = (r_state == ST_LOAD)  && (|(in_vld & r_gnt));
   assign eng_res_rdy = (r_state == ST_DRAIN) && (|(out_rdy & r_gnt));
   assign in_rdy      = ((r_state == ST_LOAD)  && eng_rdy)     ? r_gnt : '0;
   assign out_vld     = ((r_state == ST_DRAIN) && eng_res_vld) ? r_gnt : '0;
   assign out_data    = eng_res_data;
   assign eng_start   = (r_state == ST_GRANT);
   assign busy        = (r_state != ST_IDLE);
   assign gnt         = r_gnt;
   assign err         = r_err;
   assign err_ch      = r_err_ch;

   assign w_in_xfer  = eng_vld && eng_rdy;
   assign w_res_xfer = eng_res_vld && eng_res_rdy;
   assign w_g_next   = (r_gnt_idx == C_PW'(NCH - 1)) ? '0 : r_gnt_idx + C_PW'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_gnt_idx_nxt = r_gnt_idx;
      w_rr_ptr_nxt  = r_rr_ptr;
      w_cnt_nxt     = r_cnt;
      w_tmo_nxt     = r_tmo;
      w_err_nxt     = 1'b0;
      w_err_ch_nxt  = r_err_ch;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt   = ST_GRANT;
               w_gnt_idx_nxt = w_pick;
               w_gnt_nxt     = NCH'(1) << w_pick;
            end
         end
         ST_GRANT: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            if (w_in_xfer) begin
               if (r_cnt == C_CW'(2 * C_WPO - 1)) begin
                  w_cnt_nxt   = '0;
                  w_tmo_nxt   = '0;
                  w_state_nxt = ST_DRAIN;
               end else begin
                  w_cnt_nxt = r_cnt + C_CW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (w_res_xfer) begin
               w_tmo_nxt = '0;
               if (r_cnt == C_CW'(C_WPO - 1)) begin
                  w_cnt_nxt    = '0;
                  w_gnt_nxt    = '0;
                  w_rr_ptr_nxt = w_g_next;
                  w_state_nxt  = ST_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + C_CW'(1);
               end
            end else if (r_tmo == C_TW'(TMO - 1)) begin
               // Stalled engine: abandon the transaction so others can proceed.
               w_err_nxt    = 1'b1;
               w_err_ch_nxt = r_gnt_idx;
               w_cnt_nxt    = '0;
               w_gnt_nxt    = '0;
               w_rr_ptr_nxt = w_g_next;
               w_state_nxt  = ST_IDLE;
            end else begin
               w_tmo_nxt = r_tmo + C_TW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_gnt     <= '0;
         r_gnt_idx <= '0;
         r_rr_ptr  <= '0;
         r_cnt     <= '0;
         r_tmo     <= '0;
         r_err     <= 1'b0;
         r_err_ch  <= '0;
      end else if (clr) begin
         r_state   <= ST_IDLE;
         r_gnt     <= '0;
         r_gnt_idx <= '0;
         r_rr_ptr  <= '0;
         r_cnt     <= '0;
         r_tmo     <= '0;
         r_err     <= 1'b0;
         r_err_ch  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_gnt_idx <= w_gnt_idx_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_tmo     <= w_tmo_nxt;
         r_err     <= w_err_nxt;
         r_err_ch  <= w_err_ch_nxt;
      end
   end

endmodule
`default_nettype wire
